// File: rtl/eth_pkg.sv
// Shared Ethernet constants, framer state encoding and bit-order helper.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;
  localparam logic [7:0]  SFD_BYTE          = 8'hD5;
  localparam logic [10:0] MIN_PAYLOAD_BYTES = 11'd60;
  localparam logic [3:0]  IFG_CYCLES        = 4'd12;
  localparam logic [3:0]  PREAMBLE_BYTES    = 4'd7;
  localparam logic [3:0]  FCS_BYTES         = 4'd4;
  localparam logic [10:0] BYTE_CNT_MAX      = 11'h7FF;
  localparam logic [31:0] CRC_INIT          = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY          = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DRAIN,
    ST_IFG
  } framer_state_e;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_gen.sv
// Byte-wide CRC-32 (poly 0x04C11DB7, MSB-first register, data bits fed LSB first).
module crc32_gen
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        calc,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Ethernet sends each byte LSB first, so bit 0 enters the register first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (calc) begin
      crc_d = crc_step(crc_q, data_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload with min-size padding, FCS, underrun abort and IFG.
module eth_tx_framer
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       underrun
);

  framer_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [10:0]   byte_cnt_q, byte_cnt_d;
  logic [31:0]   fcs_q, fcs_d;
  logic [7:0]    txd_q, txd_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_er_q, tx_er_d;
  logic          underrun_q, underrun_d;

  logic          crc_init;
  logic          crc_calc;
  logic [7:0]    crc_data;
  logic [31:0]   crc_out;
  logic [31:0]   fcs_now;
  logic [10:0]   byte_inc;

  crc32_gen u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (crc_init),
    .calc    (crc_calc),
    .data_in (crc_data),
    .crc_out (crc_out)
  );

  assign fcs_now  = bitrev32(~crc_out);
  assign byte_inc = (byte_cnt_q == BYTE_CNT_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;

  // The IDLE->PREAMBLE edge already registers the first preamble byte, so
  // back-to-back frames see exactly IFG_CYCLES idle bytes on the wire.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    fcs_d      = fcs_q;
    txd_d      = 8'h00;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    underrun_d = 1'b0;
    crc_init   = 1'b0;
    crc_calc   = 1'b0;
    crc_data   = 8'h00;
    s_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          state_d = ST_PREAMBLE;
          txd_d   = PREAMBLE_BYTE;
          tx_en_d = 1'b1;
          cnt_d   = 4'd1;
        end
      end

      ST_PREAMBLE: begin
        txd_d      = PREAMBLE_BYTE;
        tx_en_d    = 1'b1;
        crc_init   = 1'b1;
        byte_cnt_d = 11'd0;
        if (cnt_q == PREAMBLE_BYTES - 4'd1) begin
          state_d = ST_SFD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SFD: begin
        txd_d    = SFD_BYTE;
        tx_en_d  = 1'b1;
        crc_init = 1'b1;
        state_d  = ST_DATA;
      end

      ST_DATA: begin
        s_ready = 1'b1;
        tx_en_d = 1'b1;
        if (s_valid) begin
          txd_d      = s_data;
          crc_calc   = 1'b1;
          crc_data   = s_data;
          byte_cnt_d = byte_inc;
          if (s_last) begin
            cnt_d   = 4'd0;
            state_d = (byte_inc < MIN_PAYLOAD_BYTES) ? ST_PAD : ST_FCS;
          end
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end

      ST_PAD: begin
        tx_en_d    = 1'b1;
        crc_calc   = 1'b1;
        byte_cnt_d = byte_inc;
        if (byte_inc >= MIN_PAYLOAD_BYTES) begin
          state_d = ST_FCS;
          cnt_d   = 4'd0;
        end
      end

      ST_FCS: begin
        tx_en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0: begin
            txd_d = fcs_now[7:0];
            fcs_d = fcs_now;
          end
          2'd1:    txd_d = fcs_q[15:8];
          2'd2:    txd_d = fcs_q[23:16];
          default: txd_d = fcs_q[31:24];
        endcase
        if (cnt_q == FCS_BYTES - 4'd1) begin
          state_d = ST_IFG;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_d = ST_IFG;
          cnt_d   = 4'd0;
        end
      end

      ST_IFG: begin
        if (cnt_q == IFG_CYCLES - 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      byte_cnt_q <= 11'd0;
      fcs_q      <= 32'h0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      fcs_q      <= fcs_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      underrun_q <= underrun_d;
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port s_data, input, 8, payload byte (dest MAC first, FCS excluded).
REQ-004 SHALL have port s_valid, input, 1, s_data valid.
REQ-005 SHALL have port s_last, input, 1, marks last payload byte of frame.
REQ-006 SHALL have port s_ready, output, 1, byte accepted when s_valid and s_ready are both high.
REQ-007 SHALL have port gmii_txd, output, 8, GMII transmit byte.
REQ-008 SHALL have port gmii_tx_en, output, 1, GMII transmit enable.
REQ-009 SHALL have port gmii_tx_er, output, 1, GMII transmit error.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port underrun, output, 1, one-cycle pulse on payload underrun.

Function
REQ-012 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG.
REQ-013 SHALL register gmii_txd, gmii_tx_en and gmii_tx_er, so each byte appears on the GMII outputs the cycle after its state/edge decision.
REQ-014 In IDLE with s_valid=1 at a clock edge, SHALL enter PREAMBLE; the first 0x55 SHALL appear with gmii_tx_en=1 on the following cycle.
REQ-015 PREAMBLE SHALL output exactly 7 bytes of 0x55; SFD SHALL output one byte of 0xD5.
REQ-016 SHALL initialise CRC to 0xFFFFFFFF during PREAMBLE/SFD; CRC SHALL cover payload and pad bytes only.
REQ-017 s_ready SHALL be high only in DATA and DRAIN; in DATA each accepted byte SHALL be output and fed to CRC in the same cycle.
REQ-018 SHALL count payload+pad bytes with an 11-bit counter that saturates at 2047.
REQ-019 On accepting s_last with count<60, SHALL enter PAD, emitting 0x00 bytes (CRC-included) until 60 bytes total; otherwise SHALL enter FCS directly.
REQ-020 FCS SHALL emit 4 bytes: the post-complement, bit-reversed CRC value, low byte first ([7:0], [15:8], [23:16], [31:24]), captured on the first FCS cycle.
REQ-021 In DATA with s_valid=0 (underrun), SHALL output one byte with gmii_tx_en=1, gmii_tx_er=1, pulse underrun, then enter DRAIN.
REQ-022 DRAIN SHALL hold gmii_tx_en=0 and discard accepted bytes until s_last is accepted, then enter IFG.
REQ-023 IFG SHALL hold gmii_tx_en=0 for exactly 12 cycles, then enter IDLE; s_valid held high SHALL start the next preamble on the next edge.
REQ-024 s_valid/s_last outside DATA/DRAIN SHALL be ignored (no acceptance).
REQ-025 When idle, outputs SHALL be gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, all counters to 0, CRC to 0xFFFFFFFF, s_ready=0, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, busy=0, underrun=0.
REQ-027 Reset mid-frame SHALL truncate the frame with no FCS; after release the block SHALL behave as from power-up.

Structure
REQ-028 Shared package eth_pkg SHALL hold PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, MIN_PAYLOAD_BYTES=60, IFG_CYCLES=12, and the framer state enum.
REQ-029 SHALL instantiate the team's existing crc32_gen sub-module (init, calc, data_in, crc_out), driving init in PREAMBLE/SFD and calc on each output payload/pad byte.

Verification
REQ-030 1-byte payload 0xAB: 7x0x55, 0xD5, 0xAB, 59x0x00, 4 FCS bytes; gmii_tx_en high 72 cycles.
REQ-031 60-byte payload: no pad, 72 enabled cycles; CRC-32 over payload+FCS SHALL leave residue register 0xC704DD7B.
REQ-032 Two frames, s_valid held high: exactly 12 cycles of gmii_tx_en=0 between the last FCS byte and the next 0x55.
REQ-033 s_valid dropped after 10 payload bytes: one cycle tx_en=1/tx_er=1, underrun pulse, no FCS, bytes drained to s_last, then 12-cycle IFG.
REQ-034 rst_n low during DATA byte 20: same-cycle gmii_tx_en=0, busy=0; next frame after release matches REQ-030 output exactly.
